// File: rtl/sfx_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// sfx_scheduler_pkg
// Shared definitions for the sound-effect scheduler:
//   - state_t   : scheduler FSM states (IDLE / PLAY / GAP)
//   - sfx_id_t  : encoded sound id carried on the 'active' output
//   - frame constants for long sounds, short sounds and the inter-sound gap
//   - small helpers mapping an id to its class, duration and one-hot vector
// One-hot vectors use the layout {failure, success, eat, new_input, tick},
// i.e. bit 4 is the highest priority and bit 0 the lowest.
// ----------------------------------------------------------------------------
package sfx_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SFX_NONE      = 3'd0,
      SFX_FAILURE   = 3'd1,
      SFX_SUCCESS   = 3'd2,
      SFX_EAT       = 3'd3,
      SFX_NEW_INPUT = 3'd4,
      SFX_TICK      = 3'd5
   } sfx_id_t;

   localparam int unsigned LONG_FRAMES  = 24;
   localparam int unsigned SHORT_FRAMES = 4;
   localparam int unsigned GAP_FRAMES   = 2;

   localparam int unsigned NUM_SFX  = 5;
   localparam int unsigned NUM_LONG = 3;

   // Ids 1..3 are the long class; lower id means higher priority.
   function automatic logic is_long(input logic [2:0] id);
      return (id >= SFX_FAILURE) && (id <= SFX_EAT);
   endfunction

   // Number of frame ticks a sound of the given id plays for.
   function automatic logic [4:0] play_frames(input logic [2:0] id);
      return is_long(id) ? 5'(LONG_FRAMES) : 5'(SHORT_FRAMES);
   endfunction

   // Id to one-hot {failure, success, eat, new_input, tick}.
   function automatic logic [NUM_SFX-1:0] sfx_onehot(input logic [2:0] id);
      logic [NUM_SFX-1:0] v;
      v = '0;
      case (id)
         SFX_FAILURE:   v = 5'b10000;
         SFX_SUCCESS:   v = 5'b01000;
         SFX_EAT:       v = 5'b00100;
         SFX_NEW_INPUT: v = 5'b00010;
         SFX_TICK:      v = 5'b00001;
         default:       v = 5'b00000;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/sfx_prio_enc.sv
// ----------------------------------------------------------------------------
// sfx_prio_enc
// Combinational 5-to-id priority encoder. The input vector is laid out as
// {failure, success, eat, new_input, tick}; the highest set bit wins and is
// reported as its sound id (1..5), or 0 when no bit is set.
// Ports:
//   req : in  [4:0] candidate sounds, bit 4 highest priority
//   id  : out [2:0] encoded id of the winning sound, 0 = none
// ----------------------------------------------------------------------------
module sfx_prio_enc
   import sfx_scheduler_pkg::*;
(
   input  logic [4:0] req,
   output logic [2:0] id
);

   always_comb begin
      id = SFX_NONE;
      if (req[4])      id = SFX_FAILURE;
      else if (req[3]) id = SFX_SUCCESS;
      else if (req[2]) id = SFX_EAT;
      else if (req[1]) id = SFX_NEW_INPUT;
      else if (req[0]) id = SFX_TICK;
   end

endmodule

// File: rtl/sfx_scheduler.sv
// ----------------------------------------------------------------------------
// sfx_scheduler
// Arbitrates game-event sound requests into single-cycle trigger pulses for a
// sound generator. Long sounds (failure, success, eat) are remembered in a
// pending register until they can play; short sounds (new_input, tick) are
// only taken when the scheduler is completely idle. Each sound plays for a
// number of video frames, followed by a fixed gap of silence. A pending long
// sound of higher priority cuts off whatever is playing.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   vsync               : frame sync level, a rising edge counts one frame
//   req_failure .. tick : single-cycle request strobes
//   mute                : level, silences everything and clears pending
//   sfx_failure .. tick : registered single-cycle trigger pulses
//   busy                : high whenever the FSM is not IDLE
//   active              : id of the sound currently playing (0 = none)
// ----------------------------------------------------------------------------
module sfx_scheduler
   import sfx_scheduler_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vsync,
   input  logic       req_failure,
   input  logic       req_success,
   input  logic       req_eat,
   input  logic       req_new_input,
   input  logic       req_tick,
   input  logic       mute,
   output logic       sfx_failure,
   output logic       sfx_success,
   output logic       sfx_eat,
   output logic       sfx_new_input,
   output logic       sfx_tick,
   output logic       busy,
   output logic [2:0] active
);

   localparam logic [1:0] GAP_LAST = 2'(GAP_FRAMES - 1);

   state_t             state;
   state_t             state_nxt;
   logic [NUM_LONG-1:0] pending;
   logic [4:0]         frame_cnt;
   logic [1:0]         gap_cnt;
   logic               prev_vsync;
   logic [2:0]         active_q;
   logic [NUM_SFX-1:0] sfx_q;

   logic               frame_tick;
   logic               short_ok;
   logic [NUM_SFX-1:0] cand;
   logic [2:0]         enc_id;
   logic [NUM_SFX-1:0] issue_vec;
   logic [NUM_LONG-1:0] clear_mask;
   logic [NUM_LONG-1:0] long_req;
   logic [4:0]         last_frame;

   logic               issue;
   logic               play_done;
   logic               gap_done;

   assign frame_tick = vsync && !prev_vsync;
   assign long_req   = {req_failure, req_success, req_eat};
   assign last_frame = play_frames(active_q) - 5'd1;

   // Short requests have no storage: they are taken only if nothing else is
   // going on this very cycle, otherwise they simply vanish.
   assign short_ok = (state == ST_IDLE) && (pending == '0);

   // Candidate vector for the shared encoder. In IDLE the pending long bits
   // outrank any short request by construction of the bit order; in PLAY only
   // pending long sounds are candidates (for preemption); in GAP nothing is.
   always_comb begin
      cand = '0;
      case (state)
         ST_IDLE: cand = {pending, req_new_input & short_ok, req_tick & short_ok};
         ST_PLAY: cand = {pending, 2'b00};
         default: cand = '0;
      endcase
   end

   sfx_prio_enc u_prio_enc (
      .req (cand),
      .id  (enc_id)
   );

   // ---------------------------------------------------------------- FSM ----
   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. Mute overrides everything.
   always_comb begin
      state_nxt = state;
      if (mute) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (issue)     state_nxt = ST_PLAY;
            ST_PLAY: if (play_done) state_nxt = ST_GAP;
            ST_GAP:  if (gap_done)  state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
         endcase
      end
   end

   // FSM decode: when to issue, when the current sound ends, when the gap ends.
   // A preempting issue in PLAY wins over a sound ending in the same cycle.
   always_comb begin
      issue     = 1'b0;
      play_done = 1'b0;
      gap_done  = 1'b0;
      if (!mute) begin
         case (state)
            ST_IDLE: issue = (enc_id != SFX_NONE);
            ST_PLAY: begin
               // Lower id = higher priority; active_q is never 0 in PLAY.
               issue     = (enc_id != SFX_NONE) && (enc_id < active_q);
               play_done = !issue && frame_tick && (frame_cnt == last_frame);
            end
            ST_GAP:  gap_done = frame_tick && (gap_cnt == GAP_LAST);
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------ datapath ---
   assign issue_vec  = issue ? sfx_onehot(enc_id) : '0;
   assign clear_mask = issue_vec[NUM_SFX-1:NUM_SFX-NUM_LONG];

   // Vsync edge detector runs regardless of mute so the first frame after
   // unmute is not double counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_vsync <= 1'b0;
      end else begin
         prev_vsync <= vsync;
      end
   end

   // Pending long requests: clearing by issue happens before the new request
   // is OR-ed in, so a request coinciding with its own issue is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else if (mute) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clear_mask) | long_req;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= SFX_NONE;
      end else if (mute) begin
         active_q <= SFX_NONE;
      end else if (issue) begin
         active_q <= enc_id;
      end else if (play_done) begin
         active_q <= SFX_NONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (mute || issue || play_done) begin
         frame_cnt <= '0;
      end else if ((state == ST_PLAY) && frame_tick) begin
         frame_cnt <= frame_cnt + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt <= '0;
      end else if (mute || gap_done) begin
         gap_cnt <= '0;
      end else if ((state == ST_GAP) && frame_tick) begin
         gap_cnt <= gap_cnt + 2'd1;
      end
   end

   // Trigger pulses: one cycle, at most one bit set since issue_vec is one-hot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sfx_q <= '0;
      end else begin
         sfx_q <= issue_vec;
      end
   end

   assign sfx_failure   = sfx_q[4];
   assign sfx_success   = sfx_q[3];
   assign sfx_eat       = sfx_q[2];
   assign sfx_new_input = sfx_q[1];
   assign sfx_tick      = sfx_q[0];
   assign busy          = (state != ST_IDLE);
   assign active        = active_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sfx_scheduler
// Self-checking bench for sfx_scheduler. Inputs change on the falling edge,
// outputs are sampled on the falling edge. 'cyc' counts rising edges, so a
// request driven at the falling edge while cyc==N is a request "in cycle N".
// Expected pulses {cycle, id} go into exp_q when a request is driven; the
// monitor pops one entry for every sfx_* pulse it sees.
// ----------------------------------------------------------------------------
module tb_sfx_scheduler;

   localparam logic [4:0] R_FAIL = 5'b10000;
   localparam logic [4:0] R_SUCC = 5'b01000;
   localparam logic [4:0] R_EAT  = 5'b00100;
   localparam logic [4:0] R_NEW  = 5'b00010;
   localparam logic [4:0] R_TICK = 5'b00001;

   logic       clk;
   logic       rst_n;
   logic       vsync;
   logic       req_failure, req_success, req_eat, req_new_input, req_tick;
   logic       mute;
   logic       sfx_failure, sfx_success, sfx_eat, sfx_new_input, sfx_tick;
   logic       busy;
   logic [2:0] active;

   int         cyc;
   int         pass_cnt;
   int         total_cnt;
   logic [18:0] exp_q[$];

   sfx_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .vsync         (vsync),
      .req_failure   (req_failure),
      .req_success   (req_success),
      .req_eat       (req_eat),
      .req_new_input (req_new_input),
      .req_tick      (req_tick),
      .mute          (mute),
      .sfx_failure   (sfx_failure),
      .sfx_success   (sfx_success),
      .sfx_eat       (sfx_eat),
      .sfx_new_input (sfx_new_input),
      .sfx_tick      (sfx_tick),
      .busy          (busy),
      .active        (active)
   );

   // ------------------------------------------------ clock / reset block ---
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // --------------------------------------------------------- checking ----
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
   endtask

   task automatic expect_pulse(input int c, input logic [2:0] id);
      exp_q.push_back({16'(c), id});
   endtask

   // Scoreboard monitor: every pulse must match the oldest expected entry.
   always @(negedge clk) begin
      logic [4:0]  v;
      logic [2:0]  got_id;
      logic [18:0] e;
      v = {sfx_failure, sfx_success, sfx_eat, sfx_new_input, sfx_tick};
      if (v != 5'b0) begin
         check("sfx_onehot", 32'($countones(v)), 32'd1);
         got_id = 3'd0;
         if (sfx_failure)        got_id = 3'd1;
         else if (sfx_success)   got_id = 3'd2;
         else if (sfx_eat)       got_id = 3'd3;
         else if (sfx_new_input) got_id = 3'd4;
         else                    got_id = 3'd5;
         if (exp_q.size() == 0) begin
            check("sfx_unexpected", 32'(got_id), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("sfx_id", 32'(got_id), 32'(e[2:0]));
            check("sfx_cycle", 32'(cyc[15:0]), 32'(e[18:3]));
         end
      end
   end

   // ------------------------------------------------------- driver tasks ---
   task automatic set_req(input logic [4:0] m);
      {req_failure, req_success, req_eat, req_new_input, req_tick} = m;
   endtask

   // One-cycle request; exp_id 0 means the request must not produce a pulse.
   task automatic pulse_req(input logic [4:0] m, input logic [2:0] exp_id, input int lat);
      @(negedge clk);
      set_req(m);
      if (exp_id != 3'd0) expect_pulse(cyc + lat, exp_id);
      @(negedge clk);
      set_req(5'b0);
   endtask

   // n frames, each: vsync high one cycle, low one cycle. Returns the cycle of
   // the last rising edge of vsync; the task ends on the falling edge after it.
   task automatic run_frames(input int n, output int last_tick);
      last_tick = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         vsync = 1'b1;
         last_tick = cyc;
         @(negedge clk);
         vsync = 1'b0;
      end
   endtask

   typedef struct {
      logic [4:0] req;
      logic [2:0] exp_id;
      int         lat;
      int         dur;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int t;
      pass_cnt  = 0;
      total_cnt = 0;
      rst_n = 1'b0;
      vsync = 1'b0;
      mute  = 1'b0;
      set_req(5'b0);

      vecs[0] = '{R_EAT,          3'd3, 2, 24};
      vecs[1] = '{R_FAIL,         3'd1, 2, 24};
      vecs[2] = '{R_SUCC,         3'd2, 2, 24};
      vecs[3] = '{R_NEW,          3'd4, 1, 4};
      vecs[4] = '{R_TICK,         3'd5, 1, 4};
      vecs[5] = '{R_NEW | R_TICK, 3'd4, 1, 4};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_active", 32'(active), 32'd0);
      check("rst_sfx", 32'({sfx_failure, sfx_success, sfx_eat, sfx_new_input, sfx_tick}), 32'd0);
      rst_n = 1'b1;

      // First vector (eat) lands on cycle 10.
      while (cyc < 9) @(negedge clk);

      // Table: single request from idle, play length and gap
      for (int i = 0; i < 6; i++) begin
         pulse_req(vecs[i].req, vecs[i].exp_id, vecs[i].lat);
         @(negedge clk);
         check("vec_active", 32'(active), 32'(vecs[i].exp_id));
         check("vec_busy_play", 32'(busy), 32'd1);
         run_frames(vecs[i].dur + 1, t);
         check("vec_busy_gap", 32'(busy), 32'd1);
         run_frames(1, t);
         check("vec_busy_done", 32'(busy), 32'd0);
         check("vec_active_done", 32'(active), 32'd0);
      end

      // Preemption: eat at frame 5, failure cuts in, eat is not replayed
      pulse_req(R_EAT, 3'd3, 2);
      run_frames(5, t);
      pulse_req(R_FAIL, 3'd1, 2);
      @(negedge clk);
      check("preempt_active", 32'(active), 32'd1);
      run_frames(25, t);
      check("preempt_busy_gap", 32'(busy), 32'd1);
      run_frames(1, t);
      check("preempt_busy_done", 32'(busy), 32'd0);
      run_frames(10, t);

      // Queued long sounds: failure plays, success then eat follow after gaps
      pulse_req(R_FAIL, 3'd1, 2);
      pulse_req(R_EAT, 3'd0, 0);
      pulse_req(R_SUCC, 3'd0, 0);
      check("queue_active_fail", 32'(active), 32'd1);
      run_frames(26, t);
      expect_pulse(t + 2, 3'd2);
      run_frames(26, t);
      expect_pulse(t + 2, 3'd3);
      run_frames(26, t);
      check("queue_busy_done", 32'(busy), 32'd0);

      // Request in the same cycle as its own issue re-arms the pending bit
      @(negedge clk);
      set_req(R_EAT);
      expect_pulse(cyc + 2, 3'd3);
      @(negedge clk);
      @(negedge clk);
      set_req(5'b0);
      run_frames(26, t);
      expect_pulse(t + 2, 3'd3);
      run_frames(26, t);
      check("rearm_busy_done", 32'(busy), 32'd0);

      // Short request while busy is dropped for good
      pulse_req(R_EAT, 3'd3, 2);
      pulse_req(R_TICK, 3'd0, 0);
      run_frames(26, t);
      check("short_drop_busy", 32'(busy), 32'd0);
      run_frames(4, t);

      // Mute during PLAY with eat pending
      pulse_req(R_FAIL, 3'd1, 2);
      pulse_req(R_EAT, 3'd0, 0);
      run_frames(3, t);
      @(negedge clk);
      mute = 1'b1;
      @(negedge clk);
      check("mute_busy", 32'(busy), 32'd0);
      check("mute_active", 32'(active), 32'd0);
      check("mute_pending", 32'(dut.pending), 32'd0);
      pulse_req(R_SUCC, 3'd0, 0);
      check("mute_req_dropped", 32'(dut.pending), 32'd0);
      mute = 1'b0;
      run_frames(30, t);
      check("unmute_busy", 32'(busy), 32'd0);

      // Asynchronous reset between clock edges during PLAY
      pulse_req(R_SUCC, 3'd2, 2);
      run_frames(3, t);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_active", 32'(active), 32'd0);
      check("arst_sfx", 32'({sfx_failure, sfx_success, sfx_eat, sfx_new_input, sfx_tick}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_frames(30, t);
      check("post_rst_idle", 32'(busy), 32'd0);
      pulse_req(R_SUCC, 3'd2, 2);
      @(negedge clk);
      check("post_rst_active", 32'(active), 32'd2);
      run_frames(26, t);
      check("post_rst_done", 32'(busy), 32'd0);

      repeat (4) @(negedge clk);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
